// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder. It waits for a host start pulse on the open-drain line,
// then answers with the ack preamble and a 40-bit humidity/temperature frame.
module dht11_responder #(
  parameter int CYCLES_PER_US = 50,
  parameter int MIN_START_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int ACK_LOW_US    = 80,
  parameter int ACK_HIGH_US   = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 27,
  parameter int BIT1_HIGH_US  = 70
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        transmission_line,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_checksum,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int MIN_START_CYC = MIN_START_US * CYCLES_PER_US;
  localparam int CNT_W = ($clog2(MIN_START_CYC + 1) > 24) ? $clog2(MIN_START_CYC + 1) : 24;

  localparam logic [CNT_W-1:0] START_LAST    = CNT_W'(MIN_START_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LAST     = CNT_W'(RESP_DELAY_US * CYCLES_PER_US - 1);
  localparam logic [CNT_W-1:0] ACK_LOW_LAST  = CNT_W'(ACK_LOW_US * CYCLES_PER_US - 1);
  localparam logic [CNT_W-1:0] ACK_HIGH_LAST = CNT_W'(ACK_HIGH_US * CYCLES_PER_US - 1);
  localparam logic [CNT_W-1:0] BIT_LOW_LAST  = CNT_W'(BIT_LOW_US * CYCLES_PER_US - 1);
  localparam logic [CNT_W-1:0] BIT0_LAST     = CNT_W'(BIT0_HIGH_US * CYCLES_PER_US - 1);
  localparam logic [CNT_W-1:0] BIT1_LAST     = CNT_W'(BIT1_HIGH_US * CYCLES_PER_US - 1);

  typedef enum logic [3:0] {
    IDLE,
    HOST_LOW,
    WAIT_RELEASE,
    ACK_LOW,
    ACK_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              line_p0;
  logic              line_p1;
  logic [CNT_W-1:0]  phase_cnt;
  logic [39:0]       shift_reg;
  logic [5:0]        bit_cnt;
  logic              drive_low;
  logic              load_frame;
  logic              shift_bit;

  function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input logic       invert);
    logic [7:0] sum;
    sum = a + b + c + d;
    return invert ? ~sum : sum;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

  assign transmission_line = drive_low ? 1'b0 : 1'bz;

  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    case (state)
      IDLE: begin
        if (!line_p1) state_next = HOST_LOW;
      end
      HOST_LOW: begin
        // The IDLE cycle that first saw the line low is part of the pulse, hence START_LAST.
        if (line_p1) state_next = (phase_cnt >= START_LAST) ? WAIT_RELEASE : IDLE;
      end
      WAIT_RELEASE: begin
        if (phase_cnt == RESP_LAST) begin
          state_next = ACK_LOW;
          load_frame = 1'b1;
        end
      end
      ACK_LOW: begin
        if (phase_cnt == ACK_LOW_LAST) state_next = ACK_HIGH;
      end
      ACK_HIGH: begin
        if (phase_cnt == ACK_HIGH_LAST) state_next = BIT_LOW;
      end
      BIT_LOW: begin
        if (phase_cnt == BIT_LOW_LAST) state_next = BIT_HIGH;
      end
      BIT_HIGH: begin
        if (phase_cnt == (shift_reg[39] ? BIT1_LAST : BIT0_LAST)) begin
          shift_bit  = 1'b1;
          state_next = (bit_cnt == 6'd39) ? END_LOW : BIT_LOW;
        end
      end
      END_LOW: begin
        if (phase_cnt == BIT_LOW_LAST) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stage p0/p1: line synchronizer; all other registers follow state_next so outputs align with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      line_p0     <= 1'b1;
      line_p1     <= 1'b1;
      phase_cnt   <= '0;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      drive_low   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      line_p0    <= transmission_line;
      line_p1    <= line_p0;
      state      <= state_next;
      phase_cnt  <= (state_next != state) ? '0 : sat_inc(phase_cnt);
      drive_low  <= (state_next inside {ACK_LOW, BIT_LOW, END_LOW});
      busy       <= (state_next inside {WAIT_RELEASE, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, END_LOW});
      frame_done <= (state_next == DONE);
      if (state_next == DONE) frame_count <= frame_count + 8'd1;
      if (load_frame) begin
        shift_reg <= {hum_int, hum_dec, temp_int, temp_dec,
                      frame_checksum(hum_int, hum_dec, temp_int, temp_dec, corrupt_checksum)};
        bit_cnt   <= '0;
      end else if (shift_bit) begin
        shift_reg <= {shift_reg[38:0], 1'b0};
        bit_cnt   <= bit_cnt + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Bench for dht11_responder: a host model issues start pulses and a line monitor decodes
// each reply frame, comparing it against expectations queued by the stimulus.
module tb_dht11_responder;

  localparam int CPU          = 2;
  localparam int MIN_US       = 6;
  localparam int RESP_US      = 2;
  localparam int ACK_LOW_US   = 4;
  localparam int ACK_HIGH_US  = 5;
  localparam int BIT_LOW_US   = 1;
  localparam int BIT0_US      = 1;
  localparam int BIT1_US      = 3;
  localparam int ACK_LOW_C    = ACK_LOW_US * CPU;
  localparam int ACK_HIGH_C   = ACK_HIGH_US * CPU;
  localparam int BIT_LOW_C    = BIT_LOW_US * CPU;
  localparam int BIT0_C       = BIT0_US * CPU;
  localparam int BIT1_C       = BIT1_US * CPU;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       host_low = 1'b0;
  logic [7:0] hum_int = '0;
  logic [7:0] hum_dec = '0;
  logic [7:0] temp_int = '0;
  logic [7:0] temp_dec = '0;
  logic       corrupt = 1'b0;
  wire        line;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  pullup (line);
  assign line = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .CYCLES_PER_US(CPU), .MIN_START_US(MIN_US), .RESP_DELAY_US(RESP_US),
    .ACK_LOW_US(ACK_LOW_US), .ACK_HIGH_US(ACK_HIGH_US), .BIT_LOW_US(BIT_LOW_US),
    .BIT0_HIGH_US(BIT0_US), .BIT1_HIGH_US(BIT1_US)
  ) dut (
    .clock(clock), .reset(reset), .transmission_line(line),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .corrupt_checksum(corrupt), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  initial forever #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          stray = 0;
  int          busy_rises = 0;
  logic [40:0] exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic host_pulse(input int low_us);
    @(posedge clock); #1 host_low = 1'b1;
    repeat (low_us * CPU) @(posedge clock);
    #1 host_low = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n = 0;
    while (busy !== level && n < 5000) begin
      @(posedge clock); #1;
      n++;
    end
    chk(name, 64'(busy), 64'(level));
  endtask

  task automatic wait_falls(input int count, input string name);
    int   seen = 0;
    int   cyc = 0;
    logic prev = line;
    while (seen < count && cyc < 5000) begin
      @(posedge clock); #1;
      if (prev === 1'b1 && line === 1'b0) seen++;
      prev = line;
      cyc++;
    end
    chk(name, 64'(seen), 64'(count));
  endtask

  task automatic set_bytes(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                           input logic [7:0] td, input logic cc);
    hum_int = hi; hum_dec = hd; temp_int = ti; temp_dec = td; corrupt = cc;
  endtask

  task automatic serve(input logic [39:0] frame, input logic csum_ok);
    exp_q.push_back({csum_ok, frame});
    host_pulse(MIN_US);
    wait_busy(1'b1, "busy_rise");
    wait_busy(1'b0, "busy_fall");
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    fork
      begin : monitor
        logic        prev_line;
        logic        busy_prev;
        logic        active;
        logic        tim_err;
        logic        cnt_pend;
        logic        sum_ok;
        logic [7:0]  exp_count;
        logic [7:0]  sum;
        logic [39:0] rx;
        logic [40:0] e;
        int          run;
        int          hi_idx;
        int          lo_idx;
        prev_line = 1'b1; busy_prev = 1'b0; active = 1'b0; tim_err = 1'b0; cnt_pend = 1'b0;
        exp_count = '0; rx = '0; run = 0; hi_idx = 0; lo_idx = 0;
        forever begin
          @(negedge clock);
          if (cnt_pend) begin
            chk("frame_count", 64'(frame_count), 64'(exp_count));
            cnt_pend = 1'b0;
          end
          if (!busy && !host_low && line === 1'b0) stray++;
          if (busy && !busy_prev) busy_rises++;
          busy_prev = busy;
          if (line !== prev_line) begin
            if (active && prev_line === 1'b1) begin
              if (hi_idx == 1) begin
                if (run != ACK_HIGH_C) tim_err = 1'b1;
              end else if (hi_idx >= 2 && hi_idx <= 41) begin
                if (run >= BIT0_C - 1 && run <= BIT0_C + 1) rx = {rx[38:0], 1'b0};
                else if (run >= BIT1_C - 1 && run <= BIT1_C + 1) rx = {rx[38:0], 1'b1};
                else tim_err = 1'b1;
              end
              hi_idx++;
            end else if (active) begin
              if (run != ((lo_idx == 0) ? ACK_LOW_C : BIT_LOW_C)) tim_err = 1'b1;
              lo_idx++;
            end
            run = 1;
          end else begin
            run++;
          end
          prev_line = line;
          if (reset) begin
            active = 1'b0; exp_count = '0; cnt_pend = 1'b0;
          end else begin
            if (frame_done) begin
              chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
              if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                sum = rx[39:32] + rx[31:24] + rx[23:16] + rx[15:8];
                sum_ok = (sum == rx[7:0]);
                chk("frame_data", 64'(rx), 64'(e[39:0]));
                chk("checksum_flag", 64'(sum_ok), 64'(e[40]));
                chk("frame_timing", 64'({tim_err, hi_idx == 42, lo_idx == 42}), 64'd3);
              end
              exp_count = exp_count + 8'd1;
              cnt_pend = 1'b1;
              active = 1'b0;
            end
            if (busy && !active) begin
              active = 1'b1; tim_err = 1'b0; rx = '0; hi_idx = 0; lo_idx = 0;
            end
          end
        end
      end
      begin : watchdog
        repeat (95000) @(posedge clock);
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench exceeded its cycle budget");
      end
    join_none

    // Reset state
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_line", 64'(line), 64'd1);

    // Basic frame: 0x37+0x19 = 0x50
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    serve(40'h37_00_19_00_50, 1'b1);

    // Short pulse ignored, then a normal request: 0x12+0x34+0x56+0x78 = 0x114 -> 0x14
    begin
      int s0;
      int b0;
      s0 = stray;
      b0 = busy_rises;
      host_pulse(MIN_US - 1);
      repeat (40) @(posedge clock);
      #1;
      chk("short_busy", 64'(busy_rises), 64'(b0));
      chk("short_drive", 64'(stray), 64'(s0));
    end
    set_bytes(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
    serve(40'h12_34_56_78_14, 1'b1);

    // Corrupted checksum: ~0x5A = 0xA5
    set_bytes(8'h40, 8'h00, 8'h1A, 8'h00, 1'b1);
    serve(40'h40_00_1A_00_A5, 1'b0);

    // temp_int changes during BIT_LOW of bit 5; the snapshot must hold
    set_bytes(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    exp_q.push_back({1'b1, 40'h37_00_19_00_50});
    host_pulse(MIN_US);
    wait_busy(1'b1, "busy_rise_chg");
    wait_falls(7, "falls_to_bit5");
    temp_int = 8'h22;
    wait_busy(1'b0, "busy_fall_chg");
    repeat (3) @(posedge clock);
    #1;

    // Reset during bit 20: no frame expected
    set_bytes(8'h55, 8'hAA, 8'h0F, 8'hF0, 1'b0);
    host_pulse(MIN_US);
    wait_busy(1'b1, "busy_rise_rst");
    wait_falls(22, "falls_to_bit20");
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("midrst_line", 64'(line), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_frame_count", 64'(frame_count), 64'd0);
    chk("midrst_frame_done", 64'(frame_done), 64'd0);
    repeat (20) @(posedge clock);
    #1;

    // 256 back-to-back frames; the count wraps to 0
    for (int i = 0; i < 256; i++) begin
      set_bytes(8'(i), 8'h00, 8'h00, 8'h00, 1'b0);
      serve({8'(i), 8'h00, 8'h00, 8'h00, 8'(i)}, 1'b1);
    end
    repeat (3) @(posedge clock);
    #1;
    chk("wrap_frame_count", 64'(frame_count), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("stray_drive_total", 64'(stray), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
